// File: rtl/sequencer_pkg.sv
// Shared constants and types for the step sequencer: transport states,
// widths, tempo presets and the step wrap helper.
package sequencer_pkg;

    localparam int TEMPO_W   = 22;
    localparam int NUM_STEPS = 8;
    localparam int STEP_W    = $clog2(NUM_STEPS);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2
    } transport_state_t;

    // Beat periods minus one, shared with the tempo selector.
    localparam logic [TEMPO_W-1:0] TEMPO_PRESET_0 = 22'd2499999;
    localparam logic [TEMPO_W-1:0] TEMPO_PRESET_1 = 22'd1249999;
    localparam logic [TEMPO_W-1:0] TEMPO_PRESET_2 = 22'd937499;
    localparam logic [TEMPO_W-1:0] TEMPO_PRESET_3 = 22'd624999;

    // Explicit compare so non-power-of-2 measures wrap correctly.
    function automatic logic [STEP_W-1:0] step_inc(input logic [STEP_W-1:0] s);
        return (s == STEP_W'(NUM_STEPS - 1)) ? '0 : s + 1'b1;
    endfunction

endpackage

// File: rtl/beat_scheduler_if.sv
// Transport bus between the tempo/button front end and the beat scheduler.
interface beat_scheduler_if;
    import sequencer_pkg::*;

    logic [TEMPO_W-1:0] tempo;
    logic               play_button;
    logic               stop_button;
    logic               beat_pulse;
    logic               measure_pulse;
    logic [STEP_W-1:0]  step;
    logic               playing;

    modport master (
        output tempo, play_button, stop_button,
        input  beat_pulse, measure_pulse, step, playing
    );

    modport slave (
        input  tempo, play_button, stop_button,
        output beat_pulse, measure_pulse, step, playing
    );

endinterface

// File: rtl/beat_timer.sv
// Reloadable beat-period down-counter; clear wins over load, load over enable.
module beat_timer
    import sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load_i,
    input  logic [TEMPO_W-1:0] load_val_i,
    input  logic               enable_i,
    input  logic               clear_i,
    output logic               zero_o
);

    logic [TEMPO_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (load_i)
            count_d = load_val_i;
        else if (enable_i && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_q <= '0;
        else        count_q <= count_d;
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/beat_scheduler.sv
// Transport FSM and step counter; beat period comes from beat_timer and
// tempo is only sampled when the timer reloads.
module beat_scheduler
    import sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    beat_scheduler_if.slave  bus
);

    transport_state_t  state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              beat_q, beat_d;
    logic              meas_q, meas_d;
    logic              playing_q, playing_d;
    logic              tmr_load, tmr_en, tmr_clear, tmr_zero;
    logic [STEP_W-1:0] step_nxt;

    assign step_nxt = step_inc(step_q);

    beat_timer u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_i     (tmr_load),
        .load_val_i (bus.tempo),
        .enable_i   (tmr_en),
        .clear_i    (tmr_clear),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        beat_d    = 1'b0;
        meas_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_clear = 1'b0;
        if (bus.stop_button) begin
            state_d   = STOPPED;
            step_d    = '0;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                STOPPED: begin
                    tmr_clear = 1'b1;
                    step_d    = '0;
                    // Step 0 sounds on the cycle right after the press.
                    if (bus.play_button) begin
                        state_d   = PLAYING;
                        tmr_clear = 1'b0;
                        tmr_load  = 1'b1;
                        beat_d    = 1'b1;
                        meas_d    = 1'b1;
                    end
                end
                PLAYING: begin
                    if (bus.play_button) begin
                        state_d = PAUSED;
                    end else if (tmr_zero) begin
                        tmr_load = 1'b1;
                        step_d   = step_nxt;
                        beat_d   = 1'b1;
                        meas_d   = (step_nxt == '0);
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                PAUSED: begin
                    if (bus.play_button) state_d = PLAYING;
                end
                default: begin
                    state_d   = STOPPED;
                    step_d    = '0;
                    tmr_clear = 1'b1;
                end
            endcase
        end
        playing_d = (state_d == PLAYING);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= STOPPED;
            step_q    <= '0;
            beat_q    <= 1'b0;
            meas_q    <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            beat_q    <= beat_d;
            meas_q    <= meas_d;
            playing_q <= playing_d;
        end
    end

    assign bus.beat_pulse    = beat_q;
    assign bus.measure_pulse = meas_q;
    assign bus.step          = step_q;
    assign bus.playing       = playing_q;

endmodule

// File: doc/beat_scheduler.md
Name: beat_scheduler

Overview:
- Transport controller for the step sequencer. It consumes the 22-bit tempo period from the tempo selector.
- It generates the per-beat pulse and the current step index that drive the measure/step datapath.
- It provides play/pause/stop control from debounced single-cycle button pulses.
- Tempo changes are applied only at beat boundaries, so a beat is never cut short.

Parameters:
- TEMPO_W, 22, width of the tempo period input (clock cycles per beat minus 1).
- NUM_STEPS, 8, steps per measure; must be ≥2.
- STEP_W, $clog2(NUM_STEPS), width of the step index.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- tempo  input  TEMPO_W  beat period minus 1, in clk cycles
- play_button  input  1  single-cycle pulse; toggles play/pause
- stop_button  input  1  single-cycle pulse; stop and rewind
- beat_pulse  output  1  one-cycle pulse at each beat
- measure_pulse  output  1  one-cycle pulse coincident with the beat_pulse of step 0
- step  output  STEP_W  current step index, 0..NUM_STEPS-1
- playing  output  1  high while in PLAYING

Behaviour:
- One clock. Reset is asynchronous and active-low (n_rst = 0 resets). All outputs are registered.
- Reset values:
  - state = STOPPED
  - count = 0
  - step = 0
  - beat_pulse = 0, measure_pulse = 0, playing = 0
- States are STOPPED, PLAYING, PAUSED. playing = (state == PLAYING).
- Priority:
  - stop_button beats play_button in the same cycle.
  - stop_button in any state: next state = STOPPED, count = 0, step = 0, pulses = 0.
- STOPPED:
  - Holds count = 0, step = 0, no pulses.
  - play_button → next state PLAYING, step = 0, count = tempo, beat_pulse = 1 and measure_pulse = 1 in the next cycle. Step 0 therefore sounds immediately.
- PLAYING, per cycle:
  - count ≠ 0: count = count - 1, beat_pulse = 0, measure_pulse = 0.
  - count = 0: count = tempo (sampled this cycle), step = step + 1 wrapping NUM_STEPS-1 → 0, beat_pulse = 1. measure_pulse = 1 iff the new step is 0.
  - Resulting spacing is tempo + 1 cycles between beat_pulses at steady tempo.
  - play_button → next state PAUSED. count and step hold, and no pulse is issued that cycle even if count = 0.
- PAUSED:
  - count and step frozen, pulses 0.
  - play_button → next state PLAYING. Decrementing resumes from the frozen count with no extra pulse, so the remaining beat time is preserved.
- Tempo sampling:
  - tempo is read only at a reload (play-from-stop or count = 0). Changes mid-beat take effect at the next beat.
  - tempo = 0 is legal: beat_pulse stays high every cycle, and step advances every cycle.
- Step wrap: for NUM_STEPS not a power of 2, the step compare is explicit (step == NUM_STEPS-1 → 0). It never relies on natural overflow.
- Reset mid-operation: asynchronous, forces all registers to their reset values immediately. No pulse is emitted on reset release.
- Buttons are assumed to be single-cycle synchronous pulses. Held-high levels are out of contract; each high cycle counts as a press.

Decomposition:
- Shared package sequencer_pkg:
  - TEMPO_W, NUM_STEPS, STEP_W constants.
  - transport_state_t enum {STOPPED, PLAYING, PAUSED}.
  - The tempo preset constants (2499999, 1249999, 937499, 624999), so the tempo selector and this block share one definition.
- One natural sub-module: beat_timer. It is a TEMPO_W reloadable down-counter with inputs load, load_val, enable, clear and output zero flag. The FSM and step counter stay in beat_scheduler.

Test Plan:
1. Reset then play_button with tempo = 4 → beat_pulse and measure_pulse the cycle after the press, step = 0. Next beat_pulse 5 cycles later with step = 1. The pulse after step 7 returns step = 0 with measure_pulse = 1.
2. Tempo change mid-beat: playing at tempo = 9, change to 3 two cycles after a beat → next beat still 10 cycles after the previous one, then 4-cycle spacing.
3. Pause/resume: tempo = 7, pause 3 cycles after a beat, hold 20 cycles, resume → no pulses while paused, step unchanged. Next beat arrives 5 cycles after the resume press (8 total active cycles).
4. Stop mid-measure at step = 5 → next cycle step = 0, playing = 0, no pulses. A later play_button restarts with an immediate step-0 beat and measure_pulse.
5. Simultaneous play_button and stop_button while PLAYING → STOPPED. Simultaneous press from STOPPED → stays STOPPED.
6. Async n_rst asserted mid-beat between clock edges → outputs zero immediately. tempo = 0 playback yields beat_pulse high every cycle and step incrementing every cycle.
